// File: rtl/timer_program_sequencer_if.sv
// Register-port bus between the sequencer (master) and one interval timer (slave).
// Every bus cycle completes in one clock; read data follows the address by one clock.
interface timer_program_sequencer_if;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic [15:0] tmr_readdata;
   logic        tmr_irq;

   modport master (
      output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
      input  tmr_readdata, tmr_irq
   );

   modport slave (
      input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
      output tmr_readdata, tmr_irq
   );
endinterface

// File: rtl/timer_program_sequencer.sv
// Sequences program/stop/snapshot requests and IRQ service into atomic timer bus cycles.
// IRQ service clears the timer status and counts serviced timeouts in tick_count.
module timer_program_sequencer #(
   parameter int unsigned TICK_W     = 32,
   parameter bit          AUTO_CLEAR = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_period,
   input  logic                  cmd_continuous,
   input  logic                  cmd_irq_en,
   input  logic                  stop_req,
   input  logic                  snap_req,
   output logic [31:0]           snap_value,
   output logic                  snap_valid,
   output logic                  tick,
   output logic [TICK_W-1:0]     tick_count,
   output logic                  busy,
   timer_program_sequencer_if.master tmr
);

   typedef enum logic [3:0] {
      IDLE, PRG_PL, PRG_PH, PRG_CT, STOP, CLR, CLR_G, SNP_W, SNP_L, SNP_H, SNP_D
   } state_e;

   localparam logic [2:0] A_STATUS  = 3'd0;
   localparam logic [2:0] A_CONTROL = 3'd1;
   localparam logic [2:0] A_PERIODL = 3'd2;
   localparam logic [2:0] A_PERIODH = 3'd3;
   localparam logic [2:0] A_SNAPL   = 3'd4;
   localparam logic [2:0] A_SNAPH   = 3'd5;

   state_e              state_q, state_d;
   logic [31:0]         period_q, period_d;
   logic                cont_q, cont_d;
   logic                irq_en_q, irq_en_d;
   logic                stop_armed_q, stop_armed_d;
   logic [15:0]         snap_lo_q, snap_lo_d;
   logic [31:0]         snap_value_q, snap_value_d;
   logic                snap_valid_q, snap_valid_d;
   logic                tick_q, tick_d;
   logic [TICK_W-1:0]   tick_count_q, tick_count_d;
   logic [2:0]          addr_q, addr_d;
   logic                cs_q, cs_d;
   logic                wr_n_q, wr_n_d;
   logic [15:0]         wdata_q, wdata_d;

   logic irq_pend;
   logic stop_pend;

   assign irq_pend  = AUTO_CLEAR && tmr.tmr_irq;
   assign stop_pend = stop_req && stop_armed_q;
   assign cmd_ready = (state_q == IDLE) && !irq_pend && !stop_pend;
   assign busy      = (state_q != IDLE);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
      state_d      = state_q;
      period_d     = period_q;
      cont_d       = cont_q;
      irq_en_d     = irq_en_q;
      stop_armed_d = stop_armed_q | ~stop_req;
      snap_lo_d    = snap_lo_q;
      snap_value_d = snap_value_q;
      snap_valid_d = 1'b0;
      tick_d       = 1'b0;
      tick_count_d = tick_count_q;
      addr_d       = 3'd0;
      cs_d         = 1'b0;
      wr_n_d       = 1'b1;
      wdata_d      = 16'h0000;

      case (state_q)
         IDLE: begin
            if (irq_pend) begin
               state_d = CLR;
            end else if (stop_pend) begin
               state_d      = STOP;
               stop_armed_d = 1'b0;
            end else if (cmd_valid) begin
               state_d  = PRG_PL;
               period_d = cmd_period;
               cont_d   = cmd_continuous;
               irq_en_d = cmd_irq_en;
            end else if (snap_req) begin
               state_d = SNP_W;
            end
         end
         PRG_PL: state_d = PRG_PH;
         PRG_PH: state_d = PRG_CT;
         PRG_CT: state_d = IDLE;
         STOP:   state_d = IDLE;
         CLR:    state_d = CLR_G;
         CLR_G:  state_d = IDLE;
         SNP_W:  state_d = SNP_L;
         SNP_L:  state_d = SNP_H;
         SNP_H: begin
            snap_lo_d = tmr.tmr_readdata;
            state_d   = SNP_D;
         end
         SNP_D: begin
            snap_value_d = {tmr.tmr_readdata, snap_lo_q};
            snap_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Bus cycle is decoded from the next state so it is on the pins during that state's own clock.
      case (state_d)
         PRG_PL: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PERIODL; wdata_d = period_d[15:0];
         end
         PRG_PH: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_PERIODH; wdata_d = period_d[31:16];
         end
         PRG_CT: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL;
            wdata_d = {12'h000, 1'b0, 1'b1, cont_d, irq_en_d};
         end
         STOP: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_CONTROL;
            wdata_d = {12'h000, 1'b1, 1'b0, cont_d, irq_en_d};
         end
         CLR: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_STATUS;
            tick_d       = 1'b1;
            tick_count_d = tick_count_q + TICK_W'(1);
         end
         SNP_W: begin
            cs_d = 1'b1; wr_n_d = 1'b0; addr_d = A_SNAPL;
         end
         SNP_L: begin
            cs_d = 1'b1; addr_d = A_SNAPL;
         end
         SNP_H: begin
            cs_d = 1'b1; addr_d = A_SNAPH;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         period_q     <= 32'h0;
         cont_q       <= 1'b0;
         irq_en_q     <= 1'b0;
         stop_armed_q <= 1'b0;
         snap_lo_q    <= 16'h0;
         snap_value_q <= 32'h0;
         snap_valid_q <= 1'b0;
         tick_q       <= 1'b0;
         tick_count_q <= '0;
         addr_q       <= 3'd0;
         cs_q         <= 1'b0;
         wr_n_q       <= 1'b1;
         wdata_q      <= 16'h0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         cont_q       <= cont_d;
         irq_en_q     <= irq_en_d;
         stop_armed_q <= stop_armed_d;
         snap_lo_q    <= snap_lo_d;
         snap_value_q <= snap_value_d;
         snap_valid_q <= snap_valid_d;
         tick_q       <= tick_d;
         tick_count_q <= tick_count_d;
         addr_q       <= addr_d;
         cs_q         <= cs_d;
         wr_n_q       <= wr_n_d;
         wdata_q      <= wdata_d;
      end
   end

   assign snap_value         = snap_value_q;
   assign snap_valid         = snap_valid_q;
   assign tick               = tick_q;
   assign tick_count         = tick_count_q;
   assign tmr.tmr_address    = addr_q;
   assign tmr.tmr_chipselect = cs_q;
   assign tmr.tmr_write_n    = wr_n_q;
   assign tmr.tmr_writedata  = wdata_q;

endmodule
